// File: rtl/shifter_iterative_unit_if.sv
// shifter_iterative_unit_if: request/result handshake bundle for the iterative shifter
interface shifter_iterative_unit_if;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] operand_a_i;
  logic [4:0]  shift_amount_i;
  logic        shift_left_i;
  logic        shift_arithmetic_i;
  logic        abort_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        busy_o;
  modport slave (
    input  valid_i, operand_a_i, shift_amount_i, shift_left_i, shift_arithmetic_i, abort_i, ready_i,
    output ready_o, valid_o, result_o, busy_o
  );
  modport master (
    output valid_i, operand_a_i, shift_amount_i, shift_left_i, shift_arithmetic_i, abort_i, ready_i,
    input  ready_o, valid_o, result_o, busy_o
  );
endinterface

// File: rtl/shifter_iterative_unit.sv
// shifter_iterative_unit: multi-cycle SLL/SRL/SRA unit shifting STEP bits per cycle
module shifter_iterative_unit #(
  parameter int STEP = 4
) (
  input logic                     clk_i,
  input logic                     rst_i,
  shifter_iterative_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      state, state_nx;
  logic [31:0] data, res, shifted;
  logic [4:0]  rem, k;
  logic        left, arith, sign, accept;
  if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8 || STEP == 16)) begin : g_bad_step
    $error("shifter_iterative_unit: STEP must be 1, 2, 4, 8 or 16");
  end
  assign accept = state == IDLE && bus.valid_i && !bus.abort_i;
  always_comb begin
    k       = rem < 5'(STEP) ? rem : 5'(STEP);
    shifted = left ? data << k : (arith && sign) ? ~(~data >> k) : data >> k;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? (bus.shift_amount_i != 5'd0 ? SHIFT : DONE) : IDLE;
      SHIFT:   state_nx = bus.abort_i ? IDLE : rem <= 5'(STEP) ? DONE : SHIFT;
      DONE:    state_nx = (bus.abort_i || bus.ready_i) ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data  <= '0;
      res   <= '0;
      rem   <= '0;
      left  <= 1'b0;
      arith <= 1'b0;
      sign  <= 1'b0;
    end else begin
      if (accept) begin
        data  <= bus.operand_a_i;
        rem   <= bus.shift_amount_i;
        left  <= bus.shift_left_i;
        arith <= bus.shift_arithmetic_i;
        sign  <= bus.operand_a_i[31];
      end
      if (accept && bus.shift_amount_i == 5'd0) res <= bus.operand_a_i;
      if (state == SHIFT) begin
        data <= shifted;
        rem  <= rem - k;
      end
      if (state == SHIFT && state_nx == DONE) res <= shifted;
    end
  end
  always_comb begin
    bus.ready_o  = state == IDLE;
    bus.valid_o  = state == DONE;
    bus.busy_o   = state != IDLE;
    bus.result_o = res;
  end
endmodule

// File: tb/tb_shifter_iterative_unit.sv
// tb_shifter_iterative_unit: scoreboard bench for the iterative shifter against a golden model
module tb_shifter_iterative_unit;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   rnd = 1'b0;
  bit   seen = 1'b0;
  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;
  exp_t q[$];
  shifter_iterative_unit_if bus ();
  shifter_iterative_unit #(.STEP(4)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;
  function automatic logic [31:0] golden(input logic [31:0] a, input logic [4:0] n, input logic l, input logic ar);
    if (l) return a << n;
    if (ar) return $signed(a) >>> n;
    return a >> n;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  always @(negedge clk_i) begin
    if (rst_i) begin
      q.delete();
      seen = 1'b0;
    end else begin
      if (bus.busy_o && bus.abort_i) begin
        if (q.size() != 0) void'(q.pop_front());
        seen = 1'b0;
      end else if (bus.valid_o) begin
        if (q.size() == 0) check("spurious_valid", 32'(bus.valid_o), 32'd0);
        else begin
          if (!seen) begin
            check("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
            seen = 1'b1;
          end
          check("result", bus.result_o, q[0].res);
          check("ready_o_in_done", 32'(bus.ready_o), 32'd0);
          if (bus.ready_i) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
      if (bus.ready_o && bus.valid_i && !bus.abort_i)
        q.push_back('{golden(bus.operand_a_i, bus.shift_amount_i, bus.shift_left_i, bus.shift_arithmetic_i),
                      bus.shift_amount_i == 5'd0 ? 1 : 1 + (int'(bus.shift_amount_i) + 3) / 4, cyc});
    end
  end
  task automatic tick();
    @(posedge clk_i);
    #1;
    if (rnd) begin
      bus.ready_i = $urandom_range(0, 3) != 0;
      bus.abort_i = $urandom_range(0, 15) == 0;
    end
  endtask
  task automatic issue(input logic [31:0] a, input logic [4:0] n, input logic l, input logic ar);
    int i;
    bus.operand_a_i        = a;
    bus.shift_amount_i     = n;
    bus.shift_left_i       = l;
    bus.shift_arithmetic_i = ar;
    bus.valid_i            = 1'b1;
    for (i = 0; i < 200 && !(bus.ready_o && !bus.abort_i); i++) tick();
    if (i == 200) check("accept_timeout", 32'd0, 32'd1);
    tick();
    bus.valid_i            = 1'b0;
    bus.operand_a_i        = $urandom;
    bus.shift_amount_i     = 5'($urandom);
    bus.shift_left_i       = 1'($urandom);
    bus.shift_arithmetic_i = 1'($urandom);
  endtask
  task automatic wait_valid();
    for (int i = 0; i < 100 && !bus.valid_o; i++) tick();
    check("wait_valid", 32'(bus.valid_o), 32'd1);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 200 && !(bus.ready_o && q.size() == 0); i++) tick();
    check("wait_idle", 32'(bus.ready_o && q.size() == 0), 32'd1);
  endtask
  task automatic run_dir(input string tag, input logic [31:0] a, input logic [4:0] n, input logic l, input logic ar,
                         input logic [31:0] expc);
    issue(a, n, l, ar);
    wait_valid();
    check(tag, bus.result_o, expc);
    wait_idle();
  endtask
  initial begin
    bus.valid_i = 1'b0;
    bus.operand_a_i = '0;
    bus.shift_amount_i = '0;
    bus.shift_left_i = 1'b0;
    bus.shift_arithmetic_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.ready_i = 1'b1;
    tick();
    tick();
    check("rst_ready_o", 32'(bus.ready_o), 32'd1);
    check("rst_valid_o", 32'(bus.valid_o), 32'd0);
    check("rst_busy_o", 32'(bus.busy_o), 32'd0);
    check("rst_result_o", bus.result_o, 32'd0);
    rst_i = 1'b0;
    tick();
    run_dir("sll31", 32'h0000_0001, 5'd31, 1'b1, 1'b0, 32'h8000_0000);
    run_dir("sra4", 32'h8000_0000, 5'd4, 1'b0, 1'b1, 32'hF800_0000);
    run_dir("srl31", 32'h8000_0000, 5'd31, 1'b0, 1'b0, 32'h0000_0001);
    run_dir("sra31_pos", 32'h7FFF_FFFF, 5'd31, 1'b0, 1'b1, 32'h0000_0000);
    run_dir("sra31_neg", 32'h8000_0000, 5'd31, 1'b0, 1'b1, 32'hFFFF_FFFF);
    run_dir("amt0_sll", 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    run_dir("amt0_sra", 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    run_dir("sll3", 32'hF000_000F, 5'd3, 1'b1, 1'b1, 32'h8000_0078);
    bus.ready_i = 1'b0;
    issue(32'h8765_4321, 5'd13, 1'b0, 1'b1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      bus.valid_i = i[0];
      tick();
      check("bp_result", bus.result_o, 32'hFFFC_3B2A);
      check("bp_valid_o", 32'(bus.valid_o), 32'd1);
      check("bp_ready_o", 32'(bus.ready_o), 32'd0);
    end
    bus.ready_i = 1'b1;
    bus.valid_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    check("bp_idle", 32'(bus.ready_o), 32'd1);
    check("bp_valid_drop", 32'(bus.valid_o), 32'd0);
    wait_idle();
    issue(32'h0000_0001, 5'd20, 1'b1, 1'b0);
    tick();
    tick();
    bus.abort_i = 1'b1;
    tick();
    bus.abort_i = 1'b0;
    check("abort_idle", 32'(bus.ready_o), 32'd1);
    check("abort_busy", 32'(bus.busy_o), 32'd0);
    check("abort_valid", 32'(bus.valid_o), 32'd0);
    for (int i = 0; i < 8; i++) tick();
    check("abort_no_valid", 32'(bus.valid_o), 32'd0);
    bus.valid_i = 1'b1;
    bus.abort_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    bus.abort_i = 1'b0;
    check("abort_idle_no_accept", 32'(bus.busy_o), 32'd0);
    issue(32'h8000_0000, 5'd31, 1'b0, 1'b0);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("midrst_ready_o", 32'(bus.ready_o), 32'd1);
    check("midrst_valid_o", 32'(bus.valid_o), 32'd0);
    check("midrst_busy_o", 32'(bus.busy_o), 32'd0);
    check("midrst_result_o", bus.result_o, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    check("midrst_no_valid", 32'(bus.valid_o), 32'd0);
    rnd = 1'b1;
    for (int n = 0; n < 4000; n++)
      issue($urandom, 5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom));
    rnd = 1'b0;
    bus.ready_i = 1'b1;
    bus.abort_i = 1'b0;
    wait_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
